ws2812_pixel_rx: RTL
====================

# ws2812_pixel_rx

Parametrised WS2812B serial receiver. It synchronises the raw LED data line, classifies each high pulse as a 0 or 1 bit by its measured width, and assembles bits MSB-first into whole pixel words. Each pixel is presented with its position in the frame, and each stream reset is reported with a frame summary. It sits between the input pin and the RGB→RGBW conversion logic, replacing per-bit strobing with per-pixel delivery.

## Interface
- BITS_PER_PIXEL, 24: bits per pixel word (24 = GRB, 32 = GRBW).
- SAMPLE_TIME_CLKS, 57: high-width threshold in clk cycles; width ≥ this decodes as 1, otherwise 0 (96 MHz clk).
- MIN_HIGH_CLKS, 8: high pulses narrower than this are glitches and are discarded.
- STREAM_RESET_CLKS, 4800: cycles without an edge that constitute a stream reset (~50 µs).
- IDX_W, 10: pixel index width.
- REQUIRE_LATCH, 1: if 1, ignore bits after reset until the first stream reset.
- clk  input  1  system clock, 96 MHz.
- rst_n  input  1  asynchronous active-low reset.
- sig  input  1  raw asynchronous WS2812 data line.
- pixel_valid  output  1  one-cycle strobe: pixel_data and pixel_index are valid.
- pixel_data  output  BITS_PER_PIXEL  assembled pixel; first-received bit in the MSB.
- pixel_index  output  IDX_W  0-based position of the pixel in the current frame.
- frame_end  output  1  one-cycle strobe on stream reset.
- frame_pixels  output  IDX_W+1  pixels delivered in the frame just ended; valid with frame_end.
- frame_err  output  1  frame had a glitch, a partial pixel or an index overflow; valid with frame_end.
- glitch  output  1  one-cycle strobe per discarded narrow pulse.

## Operation
- sig passes through a two-flop synchroniser to give s2; s_prev holds the previous s2. Rise = s2 & ~s_prev; fall = ~s2 & s_prev.
- cnt (width $clog2(STREAM_RESET_CLKS+1)) is set to 1 on any edge. Otherwise it increments, saturating at STREAM_RESET_CLKS.
- On fall, with w = cnt = high width in cycles:
  - w == STREAM_RESET_CLKS (saturated): no bit.
  - w < MIN_HIGH_CLKS: glitch strobe; the frame error flag is set; no bit.
  - otherwise, bit = (w ≥ SAMPLE_TIME_CLKS); the bit shifts into shreg LSB and bit_cnt increments.
- bit_cnt reaching BITS_PER_PIXEL:
  - pixel_valid=1, pixel_data=shreg including the new bit, pixel_index=idx; bit_cnt is cleared.
  - If idx < 2^IDX_W−1, idx increments. Otherwise the error flag is set, the pixel is still output, and idx holds.
  - frame_pixels_acc increments, saturating at 2^IDX_W.
- Stream reset: the cycle in which cnt increments to STREAM_RESET_CLKS with no edge. It fires once per quiet period, whether the line is high or low.
  - frame_end=1 with frame_pixels=frame_pixels_acc.
  - frame_err = error flag | (bit_cnt≠0).
  - Then idx, bit_cnt, the accumulator and the error flag are cleared.
- States:
  - SYNC: the fall logic is inactive; the stream reset goes to RUN and still strobes frame_end.
  - RUN: full decoding.
- Reset state is SYNC if REQUIRE_LATCH=1, else RUN.
- An edge and a stream reset never coincide, because an edge reloads cnt.

## Timing
- All outputs are registered. Strobes last exactly one cycle; there is no back-pressure.
- Latency: pixel_valid rises at the 3rd clk rising edge after sig falls for the last bit of the pixel.
- frame_end rises STREAM_RESET_CLKS+2 cycles after the last sig edge at the pin.
- Pulse of N cycles at the pin measures as w = N.
- Reset values: all outputs 0; pixel_data 0; synchroniser 0; cnt 0; idx 0.
  - After release, a quiet line gives frame_end with frame_pixels=0 and frame_err=0 at cycle STREAM_RESET_CLKS.
- rst_n assertion mid-pixel: immediate clear; partial bits are lost; nothing is emitted.
- Minimum back-to-back pixel spacing: BITS_PER_PIXEL × bit period. pixel_data holds until the next pixel.

## Test plan
- 24 bits 0x12_34_56 (0 = 38 high/82 low, 1 = 77 high/43 low), then 5000 low → pixel_valid once, data 0x123456, index 0; then frame_end, frame_pixels 1, frame_err 0.
- Three pixels 0xFF0000, 0x00FF00, 0x0000FF, then reset → indices 0, 1, 2; frame_pixels 3.
- Width boundaries: bits of width 56 / 57 / 7 / 8 → 0 / 1 / glitch strobe (bit dropped) / 0; the later frame_end has frame_err 1.
- REQUIRE_LATCH=1 with a pixel sent right after reset release → no pixel_valid. A frame_end occurs after 4800 quiet cycles, then the next pixel decodes with index 0.
- 12 bits, then 4800 cycles high → frame_end, frame_err 1, frame_pixels 0. The next full pixel gets index 0.
- IDX_W=2 with 5 pixels → indices 0, 1, 2, 3, 3; frame_pixels 4 (saturated); frame_err 1. rst_n pulsed mid-pixel → no output; all outputs 0.

Source files
------------

// File: rtl/ws2812_pixel_rx_if.sv
// ws2812_pixel_rx_if
// Output bundle of the WS2812 pixel receiver: per-pixel delivery and per-frame
// summary strobes.
//   master : driven by the receiver (all signals are outputs)
//   slave  : consumed by the downstream RGB->RGBW logic (all signals are inputs)
// Signals:
//   pixel_valid   one-cycle strobe, pixel_data / pixel_index valid
//   pixel_data    assembled pixel, first-received bit in the MSB
//   pixel_index   0-based position of the pixel in the current frame
//   frame_end     one-cycle strobe on a stream reset
//   frame_pixels  pixels delivered in the frame just ended
//   frame_err     frame had a glitch, a partial pixel or an index overflow
//   glitch        one-cycle strobe per discarded narrow pulse
interface ws2812_pixel_rx_if #(
  parameter int BITS_PER_PIXEL = 24,
  parameter int IDX_W          = 10
);
  logic                      pixel_valid;
  logic [BITS_PER_PIXEL-1:0] pixel_data;
  logic [IDX_W-1:0]          pixel_index;
  logic                      frame_end;
  logic [IDX_W:0]            frame_pixels;
  logic                      frame_err;
  logic                      glitch;

  modport master (
    output pixel_valid, pixel_data, pixel_index,
    output frame_end, frame_pixels, frame_err, glitch
  );

  modport slave (
    input pixel_valid, pixel_data, pixel_index,
    input frame_end, frame_pixels, frame_err, glitch
  );
endinterface

// File: rtl/ws2812_pixel_rx.sv
// ws2812_pixel_rx
// WS2812B serial receiver. Synchronises the raw data line, measures each high
// pulse, decodes it as a 0 or 1 bit by width, and assembles bits MSB-first into
// whole pixel words. Each pixel is delivered with its frame position; each
// stream reset (long quiet line) produces a frame summary.
// Ports:
//   clk    system clock (96 MHz nominal)
//   rst_n  asynchronous active-low reset
//   sig    raw asynchronous WS2812 data line
//   px     ws2812_pixel_rx_if.master output bundle (pixel and frame strobes)
module ws2812_pixel_rx #(
  parameter int BITS_PER_PIXEL    = 24,
  parameter int SAMPLE_TIME_CLKS  = 57,
  parameter int MIN_HIGH_CLKS     = 8,
  parameter int STREAM_RESET_CLKS = 4800,
  parameter int IDX_W             = 10,
  parameter int REQUIRE_LATCH     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  ws2812_pixel_rx_if.master px
);

  localparam int CNT_W = $clog2(STREAM_RESET_CLKS + 1);
  localparam int BC_W  = $clog2(BITS_PER_PIXEL + 1);

  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STREAM_RESET_CLKS);
  localparam logic [CNT_W-1:0] CNT_PRE    = CNT_W'(STREAM_RESET_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MIN    = CNT_W'(MIN_HIGH_CLKS);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_TIME_CLKS);
  localparam logic [BC_W-1:0]  BC_LAST    = BC_W'(BITS_PER_PIXEL - 1);
  localparam logic [BC_W-1:0]  BC_ONE     = BC_W'(1);
  localparam logic [IDX_W-1:0] IDX_MAX    = '1;
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W:0]   ACC_MAX    = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0]   ACC_ONE    = (IDX_W + 1)'(1);

  typedef enum logic {
    SYNC,
    RUN
  } state_t;

  localparam state_t RESET_STATE = (REQUIRE_LATCH != 0) ? SYNC : RUN;

  state_t state_q;
  state_t state_d;

  logic s1;
  logic s2;
  logic s_prev;
  logic rise;
  logic fall;
  logic edge_det;

  logic [CNT_W-1:0] cnt;
  logic             stream_reset;

  logic                      bit_take;
  logic                      glitch_det;
  logic                      bit_val;
  logic                      pixel_done;
  logic [BITS_PER_PIXEL-1:0] shreg;
  logic [BITS_PER_PIXEL-1:0] shreg_next;
  logic [BC_W-1:0]           bit_cnt;
  logic [IDX_W-1:0]          idx;
  logic [IDX_W:0]            acc;
  logic                      err_flag;

  logic                      pixel_valid_q;
  logic [BITS_PER_PIXEL-1:0] pixel_data_q;
  logic [IDX_W-1:0]          pixel_index_q;
  logic                      frame_end_q;
  logic [IDX_W:0]            frame_pixels_q;
  logic                      frame_err_q;
  logic                      glitch_q;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s1     <= sig;
      s2     <= s1;
      s_prev <= s2;
    end
  end

  assign rise     = s2 & ~s_prev;
  assign fall     = ~s2 & s_prev;
  assign edge_det = rise | fall;

  // On a fall, cnt equals the high width in cycles because it is loaded with 1
  // on the rise and counts every following high cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (edge_det) begin
      cnt <= CNT_ONE;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Fires exactly once per quiet period, on the cycle that carries cnt to
  // saturation; it cannot coincide with an edge since an edge reloads cnt.
  assign stream_reset = ~edge_det & (cnt == CNT_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and fall classification. In SYNC the fall logic is gated off so
  // that a stream joined mid-frame is ignored until the first latch.
  always_comb begin
    state_d    = state_q;
    bit_take   = 1'b0;
    glitch_det = 1'b0;
    case (state_q)
      SYNC: begin
        if (stream_reset) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (fall) begin
          if (cnt == CNT_MAX) begin
            bit_take = 1'b0;
          end else if (cnt < CNT_MIN) begin
            glitch_det = 1'b1;
          end else begin
            bit_take = 1'b1;
          end
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  assign bit_val    = (cnt >= CNT_SAMPLE);
  assign shreg_next = {shreg[BITS_PER_PIXEL-2:0], bit_val};
  assign pixel_done = bit_take & (bit_cnt == BC_LAST);

  // Bit assembly, pixel delivery and frame bookkeeping. Index overflow still
  // delivers the pixel but pins the index and flags the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg          <= '0;
      bit_cnt        <= '0;
      idx            <= '0;
      acc            <= '0;
      err_flag       <= 1'b0;
      pixel_valid_q  <= 1'b0;
      pixel_data_q   <= '0;
      pixel_index_q  <= '0;
      frame_end_q    <= 1'b0;
      frame_pixels_q <= '0;
      frame_err_q    <= 1'b0;
      glitch_q       <= 1'b0;
    end else begin
      pixel_valid_q <= 1'b0;
      frame_end_q   <= 1'b0;
      glitch_q      <= glitch_det;
      if (stream_reset) begin
        frame_end_q    <= 1'b1;
        frame_pixels_q <= acc;
        frame_err_q    <= err_flag | (bit_cnt != '0);
        idx            <= '0;
        bit_cnt        <= '0;
        acc            <= '0;
        err_flag       <= 1'b0;
      end else begin
        if (glitch_det) begin
          err_flag <= 1'b1;
        end
        if (bit_take) begin
          shreg <= shreg_next;
          if (pixel_done) begin
            pixel_valid_q <= 1'b1;
            pixel_data_q  <= shreg_next;
            pixel_index_q <= idx;
            bit_cnt       <= '0;
            if (idx != IDX_MAX) begin
              idx <= idx + IDX_ONE;
            end else begin
              err_flag <= 1'b1;
            end
            if (acc != ACC_MAX) begin
              acc <= acc + ACC_ONE;
            end
          end else begin
            bit_cnt <= bit_cnt + BC_ONE;
          end
        end
      end
    end
  end

  assign px.pixel_valid  = pixel_valid_q;
  assign px.pixel_data   = pixel_data_q;
  assign px.pixel_index  = pixel_index_q;
  assign px.frame_end    = frame_end_q;
  assign px.frame_pixels = frame_pixels_q;
  assign px.frame_err    = frame_err_q;
  assign px.glitch       = glitch_q;

endmodule
